decode_queue: RTL and testbench
===============================

# decode_queue

Buffered, parametrised main-decode stage between fetch and execute. Accepts 32-bit instructions with their PC over a valid/ready handshake, decodes the opcode into the 18-bit control bundle at enqueue, and holds up to DEPTH decoded entries in a FIFO. It also flags illegal or disabled opcodes and supports a single-cycle pipeline flush. This decouples fetch stalls from execute stalls.

## Interface
- XLEN, 32: PC width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- FPU_EN, 1: when 0, FP opcodes decode as illegal.
- CW: derived, equal to $clog2(DEPTH+1).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  discards all queued entries.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  queue can accept an instruction.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head entry.
- out_instr  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_ctrl  out  18  head control bundle.
- out_illegal  out  1  head opcode is illegal.
- count  out  CW  current occupancy, 0..DEPTH.

## Operation
- The clock is clk. Reset is asynchronous and active-high on reset.
- out_ctrl field order, MSB to LSB: reg_write, imm_src[2:0], alu_src_b, mem_write, result_src[1:0], branch, alu_op[1:0], jump, jump_r, fpu, fpu_result_src, fpu_src_a, fpu_src_b, lw.
- The opcode is in_instr[6:0]. The control bundle for each opcode, using the field grouping above, is:
  - 0000011 (LW): 1_000_1_0_01_0_00_00_0000_1
  - 0100011 (SW): 0_001_1_1_00_0_00_00_0000_0
  - 0000111 (FLW): 1_000_1_0_01_0_00_00_1000_1
  - 0100111 (FSW): 0_001_1_1_00_0_00_00_1001_0
  - 0110011 (R-type): 1_000_0_0_00_0_10_00_0000_0
  - 1010011 (FP R-type): 1_000_0_0_00_0_10_00_1111_0
  - 1100011 (branch): 0_010_0_0_00_1_01_00_0000_0
  - 0010011 (I-type ALU): 1_000_1_0_00_0_10_00_0000_0
  - 1101111 (JAL): 1_011_0_0_10_0_00_10_0000_0
  - 1100111 (JALR): 1_000_1_0_10_0_00_01_0000_0
  - 0110111 (LUI): 1_100_1_0_00_0_11_00_0000_0
- Illegal: any other opcode, or an FP opcode (FLW, FSW, FP R-type) when FPU_EN=0. An illegal entry has ctrl = 18'b0 and illegal=1. It is still queued and delivered, never dropped. The output never carries X.
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a CW-bit count.
- Push: in_valid && in_ready && !flush. Writes instr, pc, decoded ctrl and illegal at the tail, then advances the tail.
- Pop: out_valid && out_ready && !flush. Advances the head.
- in_ready = (count != DEPTH) && !flush. There is no same-cycle bypass when full: a pop while full does not raise in_ready that cycle.
- out_valid = (count != 0) && !flush. out_instr, out_pc, out_ctrl and out_illegal come directly from the head entry register.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Push only: count+1. Pop only: count-1.
- Flush: next state is head=tail=0 and count=0. Any concurrent push or pop is ignored. Payload RAM is not cleared.
- Reset: same state as flush, asynchronously. Reset values: in_ready=1 once reset deasserts, out_valid=0, count=0, out_ctrl=0, out_illegal=0, out_instr=0, out_pc=0. Reset mid-stream loses all entries.

## Timing
- Latency: an instruction accepted at edge N appears with out_valid=1 in the cycle after edge N. Minimum enqueue-to-dequeue is one cycle. No combinational path from in_* to out_*.
- in_ready depends only on count and flush, not on out_ready.
- A held, un-popped head keeps all out_* stable until popped or flushed.
- Throughput: one push and one pop per cycle, sustained when 0 < count < DEPTH.
- Decode is combinational on in_instr before the storage write. The decoded result is captured at the same edge as the push.

## Test plan
- Reset, then push LW 0x00002083 at pc 0x100 with out_ready=0. Next cycle: out_valid=1, out_ctrl=18'b1_000_1_0_01_0_00_00_0000_1, out_illegal=0, count=1.
- Push DEPTH=4 instructions with out_ready=0. Required: count=4, in_ready=0. The next push attempt is not accepted. Then pop all 4: PCs emerge in push order, count returns to 0, and pointers wrap.
- Streaming with in_valid=out_ready=1 over 20 cycles of mixed opcodes. Required: count stays at 1 and each out_ctrl matches the bundle table.
- Opcode 0000000 → out_illegal=1, ctrl=0. With FPU_EN=0, FLW 0x00002007 → out_illegal=1. With FPU_EN=1, the same FLW gives ctrl=18'b1_000_1_0_01_0_00_00_1000_1.
- count=3, then assert flush together with in_valid and out_ready. Required: that cycle in_ready=0 and out_valid=0. Next cycle count=0 and out_valid=0. The flushed push never emerges.
- Assert reset asynchronously mid-cycle with count=2. Required: out_valid=0 and count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: main-decode stage with a DEPTH-entry FIFO between fetch and execute.
// Instructions are decoded at enqueue; the head entry drives the outputs directly.
module decode_queue #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 4,
  parameter bit          FPU_EN = 1'b1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [17:0]     out_ctrl,
  output logic            out_illegal,
  output logic [CW-1:0]   count
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CTRLW = 18;

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_FLW   = 7'b0000111;
  localparam logic [6:0] OP_FSW   = 7'b0100111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_FPR   = 7'b1010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic [31:0]      instr_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [CTRLW-1:0] ctrl_mem  [DEPTH];
  logic             ill_mem   [DEPTH];

  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic [CTRLW-1:0] dec_ctrl;
  logic             dec_illegal;
  logic             push;
  logic             pop;

  // Handshake qualifiers; flush suppresses both sides for the cycle
  assign in_ready  = (count_q != CW'(DEPTH)) && !flush;
  assign out_valid = (count_q != CW'(0)) && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Main decode of the incoming opcode; unknown or disabled FP opcodes are illegal
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      OP_LW:   dec_ctrl = 18'b1_000_1_0_01_0_00_00_0000_1;
      OP_SW:   dec_ctrl = 18'b0_001_1_1_00_0_00_00_0000_0;
      OP_R:    dec_ctrl = 18'b1_000_0_0_00_0_10_00_0000_0;
      OP_BR:   dec_ctrl = 18'b0_010_0_0_00_1_01_00_0000_0;
      OP_I:    dec_ctrl = 18'b1_000_1_0_00_0_10_00_0000_0;
      OP_JAL:  dec_ctrl = 18'b1_011_0_0_10_0_00_10_0000_0;
      OP_JALR: dec_ctrl = 18'b1_000_1_0_10_0_00_01_0000_0;
      OP_LUI:  dec_ctrl = 18'b1_100_1_0_00_0_11_00_0000_0;
      OP_FLW: begin
        if (FPU_EN) dec_ctrl = 18'b1_000_1_0_01_0_00_00_1000_1;
        else        dec_illegal = 1'b1;
      end
      OP_FSW: begin
        if (FPU_EN) dec_ctrl = 18'b0_001_1_1_00_0_00_00_1001_0;
        else        dec_illegal = 1'b1;
      end
      OP_FPR: begin
        if (FPU_EN) dec_ctrl = 18'b1_000_0_0_00_0_10_00_1111_0;
        else        dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Pointer and occupancy tracking; flush and reset both empty the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Payload storage; cleared only by reset so the outputs are never X
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
        ctrl_mem[i]  <= '0;
        ill_mem[i]   <= 1'b0;
      end
    end else if (push) begin
      instr_mem[tail_q] <= in_instr;
      pc_mem[tail_q]    <= in_pc;
      ctrl_mem[tail_q]  <= dec_ctrl;
      ill_mem[tail_q]   <= dec_illegal;
    end
  end

  assign out_instr   = instr_mem[head_q];
  assign out_pc      = pc_mem[head_q];
  assign out_ctrl    = ctrl_mem[head_q];
  assign out_illegal = ill_mem[head_q];
  assign count       = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: scoreboard of expected entries, one task per scenario.
module tb_decode_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready,    in_ready2;
  logic        out_valid,   out_valid2;
  logic [31:0] out_instr,   out_instr2;
  logic [31:0] out_pc,      out_pc2;
  logic [17:0] out_ctrl,    out_ctrl2;
  logic        out_illegal, out_illegal2;
  logic [2:0]  count,       count2;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [17:0] ctrl;
    logic        ill;
    logic [17:0] ctrl2;
    logic        ill2;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] tbl [12] = '{
    32'h00002083, 32'h00112023, 32'h00002007, 32'h00112027,
    32'h002081b3, 32'h00208053, 32'h00208063, 32'h00108093,
    32'h0080006f, 32'h00008067, 32'h000010b7, 32'h0000007f
  };

  decode_queue #(.XLEN(32), .DEPTH(DEPTH), .FPU_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .out_illegal(out_illegal), .count(count)
  );

  decode_queue #(.XLEN(32), .DEPTH(DEPTH), .FPU_EN(1'b0)) dut_nofpu (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2),
    .out_ctrl(out_ctrl2), .out_illegal(out_illegal2), .count(count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decode table
  function automatic logic [17:0] exp_ctrl(input logic [31:0] ins, input bit fpu);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'b0000011: exp_ctrl = 18'b1_000_1_0_01_0_00_00_0000_1;
      7'b0100011: exp_ctrl = 18'b0_001_1_1_00_0_00_00_0000_0;
      7'b0000111: exp_ctrl = fpu ? 18'b1_000_1_0_01_0_00_00_1000_1 : 18'b0;
      7'b0100111: exp_ctrl = fpu ? 18'b0_001_1_1_00_0_00_00_1001_0 : 18'b0;
      7'b0110011: exp_ctrl = 18'b1_000_0_0_00_0_10_00_0000_0;
      7'b1010011: exp_ctrl = fpu ? 18'b1_000_0_0_00_0_10_00_1111_0 : 18'b0;
      7'b1100011: exp_ctrl = 18'b0_010_0_0_00_1_01_00_0000_0;
      7'b0010011: exp_ctrl = 18'b1_000_1_0_00_0_10_00_0000_0;
      7'b1101111: exp_ctrl = 18'b1_011_0_0_10_0_00_10_0000_0;
      7'b1100111: exp_ctrl = 18'b1_000_1_0_10_0_00_01_0000_0;
      7'b0110111: exp_ctrl = 18'b1_100_1_0_00_0_11_00_0000_0;
      default:    exp_ctrl = 18'b0;
    endcase
  endfunction

  function automatic logic exp_ill(input logic [31:0] ins, input bit fpu);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
      7'b1101111, 7'b1100111, 7'b0110111: exp_ill = 1'b0;
      7'b0000111, 7'b0100111, 7'b1010011: exp_ill = !fpu;
      default: exp_ill = 1'b1;
    endcase
  endfunction

  // Advance one clock; scoreboard follows the accept/consume rules of the queue
  task automatic tick();
    ent_t e;
    ent_t d;
    bit   do_push, do_pop, do_flush;
    do_flush = flush;
    do_push  = in_valid && !flush && (sb.size() < DEPTH);
    do_pop   = out_ready && !flush && (sb.size() != 0);
    e.instr = in_instr;
    e.pc    = in_pc;
    e.ctrl  = exp_ctrl(in_instr, 1'b1);
    e.ill   = exp_ill(in_instr, 1'b1);
    e.ctrl2 = exp_ctrl(in_instr, 1'b0);
    e.ill2  = exp_ill(in_instr, 1'b0);
    @(posedge clk);
    if (do_flush) sb.delete();
    else begin
      if (do_pop) d = sb.pop_front();
      if (do_push) sb.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_ctrl !== 18'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", out_ctrl); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", out_illegal); end
    checks++; if (out_instr !== 32'd0 || out_pc !== 32'd0) begin errors++; $display("FAIL reset_payload got %h/%h want 0/0", out_instr, out_pc); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    sb.delete();
  endtask

  task automatic test_single_lw();
    in_valid = 1'b1; in_instr = 32'h00002083; in_pc = 32'h100; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_valid got %b want 1", out_valid); end
    checks++; if (out_ctrl !== 18'b1_000_1_0_01_0_00_00_0000_1) begin errors++; $display("FAIL lw_ctrl got %b want 100010010000000001", out_ctrl); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL lw_illegal got %b want 0", out_illegal); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL lw_count got %0d want 1", count); end
    checks++; if (out_pc !== sb[0].pc) begin errors++; $display("FAIL lw_pc got %h want %h", out_pc, sb[0].pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL lw_drain got count %0d valid %b want 0/0", count, out_valid); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_instr = tbl[i + 4]; in_pc = 32'h200 + 32'(4 * i);
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    in_instr = 32'h00002083; in_pc = 32'h999;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d want 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_pop_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_pc !== sb[0].pc || out_instr !== sb[0].instr) begin errors++; $display("FAIL full_pop_order[%0d] got %h/%h want %h/%h", i, out_pc, out_instr, sb[0].pc, sb[0].instr); end
      checks++; if (out_ctrl !== sb[0].ctrl) begin errors++; $display("FAIL full_pop_ctrl[%0d] got %b want %b", i, out_ctrl, sb[0].ctrl); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got count %0d valid %b want 0/0", count, out_valid); end
  endtask

  task automatic test_stream();
    in_valid = 1'b1; in_instr = tbl[0]; in_pc = 32'hF00; out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_instr = tbl[i % 12]; in_pc = 32'h1000 + 32'(4 * i);
      checks++; if (count !== 3'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL stream_count[%0d] got count %0d valid %b want 1/1", i, count, out_valid); end
      checks++; if (out_pc !== sb[0].pc) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, sb[0].pc); end
      checks++; if (out_ctrl !== sb[0].ctrl || out_illegal !== sb[0].ill) begin errors++; $display("FAIL stream_ctrl[%0d] got %b/%b want %b/%b", i, out_ctrl, out_illegal, sb[0].ctrl, sb[0].ill); end
      checks++; if (out_ctrl2 !== sb[0].ctrl2 || out_illegal2 !== sb[0].ill2) begin errors++; $display("FAIL stream_nofpu[%0d] got %b/%b want %b/%b", i, out_ctrl2, out_illegal2, sb[0].ctrl2, sb[0].ill2); end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_pc !== sb[0].pc) begin errors++; $display("FAIL stream_last_pc got %h want %h", out_pc, sb[0].pc); end
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_drain got %0d want 0", count); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h300;
    tick();
    in_valid = 1'b0;
    checks++; if (out_illegal !== 1'b1 || out_ctrl !== 18'd0) begin errors++; $display("FAIL illegal_op0 got %b/%h want 1/0", out_illegal, out_ctrl); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin errors++; $display("FAIL illegal_delivered got %b/%h want 1/300", out_valid, out_pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00002007; in_pc = 32'h304;
    tick();
    in_valid = 1'b0;
    checks++; if (out_ctrl !== 18'b1_000_1_0_01_0_00_00_1000_1 || out_illegal !== 1'b0) begin errors++; $display("FAIL flw_fpu got %b/%b want 100010010000010001/0", out_ctrl, out_illegal); end
    checks++; if (out_illegal2 !== 1'b1 || out_ctrl2 !== 18'd0) begin errors++; $display("FAIL flw_nofpu got %b/%h want 1/0", out_illegal2, out_ctrl2); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = tbl[i]; in_pc = 32'h400 + 32'(4 * i);
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", count); end
    in_instr = 32'h002081b3; in_pc = 32'h7FC; out_ready = 1'b1; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_handshake got %b/%b want 0/0", in_ready, out_valid); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got %0d/%b want 0/0", count, out_valid); end
    checks++; if (count2 !== 3'd0) begin errors++; $display("FAIL flush_nofpu_count got %0d want 0", count2); end
    in_valid = 1'b1; in_instr = 32'h000010b7; in_pc = 32'h800;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1 || out_pc !== sb[0].pc) begin errors++; $display("FAIL flush_next_head got %0d/%h want 1/%h", count, out_pc, sb[0].pc); end
    checks++; if (out_ctrl !== sb[0].ctrl) begin errors++; $display("FAIL flush_next_ctrl got %b want %b", out_ctrl, sb[0].ctrl); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = tbl[i + 6]; in_pc = 32'h500 + 32'(4 * i);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL areset_pre_count got %0d want 2", count); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL areset_immediate got %b/%0d want 0/0", out_valid, count); end
    checks++; if (out_pc !== 32'd0 || out_ctrl !== 18'd0) begin errors++; $display("FAIL areset_payload got %h/%h want 0/0", out_pc, out_ctrl); end
    sb.delete();
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL areset_release got %b/%0d want 1/0", in_ready, count); end
  endtask

  initial begin
    test_reset();
    test_single_lw();
    test_full();
    test_stream();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
